weight_ram_banked_burst: RTL and testbench
==========================================

Name: weight_ram_banked_burst

Overview:
- Parametrised successor to the single-bank 17-bit x 64 weight store.
- NUM_BANKS parallel banks of DEPTH x WIDTH words, one per neuron lane of the para-N datapath.
- Writes go to one bank, or broadcast to all banks.
- Reads are burst-sequenced by an internal FSM: one address per cycle, all banks read in parallel, registered output with valid/last framing. Feeds the MAC lanes.

Parameters:
- WIDTH, 17, bits per word.
- DEPTH, 64, words per bank; must satisfy DEPTH <= 2^AW.
- AW, 6, address width.
- NUM_BANKS, 8, parallel banks/lanes.
- BW, 3, bank-select width; must satisfy NUM_BANKS <= 2^BW.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- WR  in  1  write strobe.
- wr_broadcast  in  1  when 1 with WR: write same word to all banks; wr_bank ignored.
- wr_bank  in  BW  target bank.
- wr_address_word  in  AW  write address.
- wr_data_word  in  WIDTH  write data.
- rd_start  in  1  burst request, sampled only when rd_busy=0.
- rd_base  in  AW  first burst address.
- rd_len  in  AW+1  burst length in words, 1..DEPTH.
- rd_busy  out  1  burst in progress.
- rd_reject  out  1  one-cycle pulse: request refused.
- rd_valid  out  1  rd_data/rd_address valid this cycle.
- rd_last  out  1  final word of burst, coincides with rd_valid.
- rd_address  out  AW  address of the word on rd_data.
- rd_data  out  NUM_BANKS*WIDTH  bank k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - FSM to IDLE.
  - rd_busy, rd_valid, rd_last, rd_reject, rd_address and rd_data all 0.
  - Internal counters 0.
  - Memory contents are not reset.
  - Reset mid-burst aborts immediately; no further rd_valid.
- Write:
  - Synchronous on the edge with WR=1.
  - Dropped silently if wr_address_word >= DEPTH.
  - Dropped silently if wr_bank >= NUM_BANKS and wr_broadcast=0.
  - Writes are independent of the FSM and allowed during bursts.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - rd_start=1 with rd_base < DEPTH and 1 <= rd_len <= DEPTH: load addr=rd_base, remaining=rd_len; go to BURST; rd_busy=1 from the next cycle.
  - rd_start=1 otherwise: rd_reject pulses for 1 cycle; stay in IDLE.
- BURST, each edge:
  - All banks are read at addr; the result is registered into rd_data, and rd_address=addr, rd_valid=1.
  - addr increments and wraps DEPTH-1 -> 0 (modulo DEPTH, not 2^AW).
  - remaining decrements.
  - When remaining==1 at the edge: that read is the last one; set rd_last=1 and go to DRAIN.
- DRAIN: one cycle presenting the last word; next edge clears rd_valid, rd_last and rd_busy and returns to IDLE.
- Latency:
  - rd_start sampled at edge E0; first rd_valid after E1 with data[rd_base].
  - Words are contiguous, one per cycle; rd_last is high on word rd_len.
- rd_busy timing: high from after E0 through the cycle rd_last is high.
- rd_start while rd_busy=1 is ignored, with no reject pulse. The earliest new start is the cycle after rd_last.
- rd_data holds its last value when rd_valid=0.
- Read/write same bank, same address, same edge: behaviour is set by the optional feature below.
  - Other banks are unaffected.
  - A broadcast write collides on every bank.

Optional Feature:
- Macro WEIGHT_RAM_BYPASS_EN.
- Defined: colliding lanes return the new write data in that rd_data word (write-first forwarding).
- Undefined: colliding lanes return the pre-write contents (read-first); the new data is visible on the next read of that address.

Test Plan:
- Broadcast-write addr 0..63 with data=addr+0x100; burst base=0 len=64:
  - 64 contiguous rd_valid, lane k word n = n+0x100 for all 8 lanes.
  - rd_last only on n=63.
  - First valid 2 edges after start.
- Write bank 5 addr 10 = 0x1ABCD, other banks 0; burst base=10 len=1:
  - single valid+last.
  - lane 5 = 0x1ABCD, others 0.
  - rd_busy high exactly 2 cycles.
- Wrap: burst base=62 len=4 -> rd_address sequence 62,63,0,1 with matching data.
- Rejects:
  - rd_len=0 -> rd_reject 1 cycle, no valid.
  - rd_len=65 -> rd_reject 1 cycle, no valid.
  - rd_base=63 len=64 accepted; the final word is address 62.
  - wr_bank=7 (NUM_BANKS=6 build) -> memory unchanged.
- Collision: during a burst, write bank 2 at the address being read, old=0x00011, new=0x00022:
  - lane 2 = 0x00022 with WEIGHT_RAM_BYPASS_EN.
  - lane 2 = 0x00011 without; the re-read returns 0x00022.
- Pull RESET_N low mid-burst at word 7 of 20:
  - outputs go to 0 asynchronously.
  - after release, rd_start base=0 len=3 runs normally.
  - rd_start asserted during a burst has no effect.

Source files
------------

// File: rtl/weight_ram_banked_burst.sv
// weight_ram_banked_burst
// NUM_BANKS parallel weight banks (DEPTH x WIDTH each), one per neuron lane.
// Writes target one bank or broadcast to all banks. Reads are burst-sequenced:
// one address per cycle, every bank read in parallel, registered output with
// valid/last framing for the MAC lanes.
//
// Optional build macro: WEIGHT_RAM_BYPASS_EN
//   defined   -> a lane whose bank is written at the address being read on the
//                same edge returns the new write data (write-first).
//   undefined -> that lane returns the pre-write contents (read-first).
//
// Handshake: rd_start is sampled only while rd_busy=0. A legal request starts
// a burst (rd_busy rises the next cycle); an illegal one produces a single
// rd_reject pulse. Words then arrive on contiguous cycles with rd_valid=1 and
// rd_last=1 on the final word; there is no back-pressure.
//
// dbg_state exposes the burst FSM state for observation.

module weight_ram_banked_burst #(
    parameter int WIDTH     = 17,
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int NUM_BANKS = 8,
    parameter int BW        = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    input  logic                         WR,
    input  logic                         wr_broadcast,
    input  logic [BW-1:0]                wr_bank,
    input  logic [AW-1:0]                wr_address_word,
    input  logic [WIDTH-1:0]             wr_data_word,
    input  logic                         rd_start,
    input  logic [AW-1:0]                rd_base,
    input  logic [AW:0]                  rd_len,
    output logic                         rd_busy,
    output logic                         rd_reject,
    output logic                         rd_valid,
    output logic                         rd_last,
    output logic [AW-1:0]                rd_address,
    output logic [NUM_BANKS*WIDTH-1:0]   rd_data,
    output logic [1:0]                   dbg_state
);

    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_EXT = LW'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LW-1:0] ONE_LEN   = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Storage: not reset, contents survive RESET_N
    logic [WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];

    logic [NUM_BANKS-1:0]        bank_we;
    logic                        wr_addr_ok;
    logic [NUM_BANKS*WIDTH-1:0]  rd_word;
    logic                        start_ok;

    state_t                      state_q, state_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [LW-1:0]               remaining_q, remaining_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_last_q, rd_last_d;
    logic                        rd_reject_q, rd_reject_d;
    logic [AW-1:0]               rd_address_q, rd_address_d;
    logic [NUM_BANKS*WIDTH-1:0]  rd_data_q, rd_data_d;

    // Per-bank write enables: out-of-range address or bank drops the write
    always_comb begin
        wr_addr_ok = ({1'b0, wr_address_word} < DEPTH_EXT);
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_we[k] = WR && wr_addr_ok && (wr_broadcast || (wr_bank == BW'(k)));
        end
    end

    // Bank write port, independent of the burst FSM
    always_ff @(posedge CLOCK_50) begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_we[k]) begin
                mem_q[k][wr_address_word] <= wr_data_word;
            end
        end
    end

    // Parallel read of all banks at the burst address, with optional forwarding
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            rd_word[k*WIDTH +: WIDTH] = mem_q[k][addr_q];
`ifdef WEIGHT_RAM_BYPASS_EN
            if (bank_we[k] && (wr_address_word == addr_q)) begin
                rd_word[k*WIDTH +: WIDTH] = wr_data_word;
            end
`endif
        end
    end

    // Request legality: base inside the bank, length 1..DEPTH
    always_comb begin
        start_ok = ({1'b0, rd_base} < DEPTH_EXT)
                && (rd_len != '0)
                && (rd_len <= DEPTH_EXT);
    end

    // Burst FSM next-state and output-register inputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        rd_reject_d  = 1'b0;
        rd_address_d = rd_address_q;
        rd_data_d    = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    if (start_ok) begin
                        addr_d      = rd_base;
                        remaining_d = rd_len;
                        state_d     = S_BURST;
                    end else begin
                        rd_reject_d = 1'b1;
                    end
                end
            end
            S_BURST: begin
                rd_data_d    = rd_word;
                rd_address_d = addr_q;
                rd_valid_d   = 1'b1;
                // Wrap modulo DEPTH, which may be smaller than 2^AW
                addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
                remaining_d  = remaining_q - ONE_LEN;
                if (remaining_q == ONE_LEN) begin
                    rd_last_d = 1'b1;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last word is on the outputs this cycle; defaults clear framing
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered read outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_reject_q  <= 1'b0;
            rd_address_q <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_reject_q  <= rd_reject_d;
            rd_address_q <= rd_address_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Busy covers the whole burst including the cycle the last word is shown
    always_comb begin
        rd_busy    = (state_q != S_IDLE);
        rd_reject  = rd_reject_q;
        rd_valid   = rd_valid_q;
        rd_last    = rd_last_q;
        rd_address = rd_address_q;
        rd_data    = rd_data_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_weight_ram_banked_burst.sv
// Directed testbench for weight_ram_banked_burst. A second instance built with
// NUM_BANKS=6 shares all inputs so out-of-range bank writes can be observed.
module tb_weight_ram_banked_burst;

    localparam int W   = 17;
    localparam int D   = 64;
    localparam int AW  = 6;
    localparam int LW  = AW + 1;
    localparam int NB  = 8;
    localparam int BW  = 3;
    localparam int DW  = NB * W;
    localparam int NB2 = 6;
    localparam int DW2 = NB2 * W;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic RESET_N;

    logic          WR, wr_broadcast, rd_start;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_address_word, rd_base;
    logic [W-1:0]  wr_data_word;
    logic [LW-1:0] rd_len;

    logic          rd_busy, rd_reject, rd_valid, rd_last;
    logic [AW-1:0] rd_address;
    logic [DW-1:0] rd_data;
    logic [1:0]    dbg_state;

    logic          rd_busy2, rd_reject2, rd_valid2, rd_last2;
    logic [AW-1:0] rd_address2;
    logic [DW2-1:0] rd_data2;
    logic [1:0]    dbg_state2;

    weight_ram_banked_burst #(.WIDTH(W), .DEPTH(D), .AW(AW), .NUM_BANKS(NB), .BW(BW)) dut (
        .CLOCK_50(clk), .RESET_N(RESET_N), .WR(WR), .wr_broadcast(wr_broadcast),
        .wr_bank(wr_bank), .wr_address_word(wr_address_word), .wr_data_word(wr_data_word),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .rd_busy(rd_busy), .rd_reject(rd_reject), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_address(rd_address), .rd_data(rd_data), .dbg_state(dbg_state)
    );

    weight_ram_banked_burst #(.WIDTH(W), .DEPTH(D), .AW(AW), .NUM_BANKS(NB2), .BW(BW)) dut6 (
        .CLOCK_50(clk), .RESET_N(RESET_N), .WR(WR), .wr_broadcast(wr_broadcast),
        .wr_bank(wr_bank), .wr_address_word(wr_address_word), .wr_data_word(wr_data_word),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .rd_busy(rd_busy2), .rd_reject(rd_reject2), .rd_valid(rd_valid2), .rd_last(rd_last2),
        .rd_address(rd_address2), .rd_data(rd_data2), .dbg_state(dbg_state2)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0]  model [NB][D];
    logic [DW-1:0] exp_q [$];
    int mid_base_v = 0;
    int mid_len_v  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int a);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v[k*W +: W] = model[k][a];
        return v;
    endfunction

    // Driver: one write, held across one rising edge
    task automatic do_write(input logic bcast, input int bank, input int addr, input logic [W-1:0] data);
        WR = 1'b1; wr_broadcast = bcast; wr_bank = BW'(bank);
        wr_address_word = AW'(addr); wr_data_word = data;
        @(negedge clk);
        WR = 1'b0; wr_broadcast = 1'b0;
        for (int k = 0; k < NB; k++) if (bcast || k == bank) model[k][addr] = data;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  DW'(rd_busy),   '0);
        check({tag, "_valid"}, DW'(rd_valid),  '0);
        check({tag, "_last"},  DW'(rd_last),   '0);
        check({tag, "_rej"},   DW'(rd_reject), '0);
    endtask

    // Driver: illegal request must pulse rd_reject once and start nothing
    task automatic try_reject(input string tag, input int base, input int len);
        rd_start = 1'b1; rd_base = AW'(base); rd_len = LW'(len);
        @(negedge clk);
        rd_start = 1'b0;
        check({tag, "_pulse"}, DW'(rd_reject), DW'(1));
        check({tag, "_nobusy"}, DW'(rd_busy), '0);
        @(negedge clk);
        check_idle_outputs({tag, "_after"});
    endtask

    // Driver + scoreboard for one burst; optional collision write, mid-burst
    // start request and reset abort
    task automatic run_burst(input string tag, input int base, input int len,
                             input int coll_idx, input int coll_bank, input logic [W-1:0] coll_data,
                             input int abort_at, input int mid_at);
        int n = 0; int first_c = -1; int busy_c = 0; int rej_c = 0; int a;
        bit done = 0; bit aborted = 0;
        logic [DW-1:0] e;
        logic [DW-1:0] last_e = '0;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            e = exp_word((base + i) % D);
`ifdef WEIGHT_RAM_BYPASS_EN
            if (i == coll_idx) e[coll_bank*W +: W] = coll_data;
`endif
            exp_q.push_back(e);
        end
        rd_start = 1'b1; rd_base = AW'(base); rd_len = LW'(len);
        @(negedge clk);
        for (int c = 1; c <= len + 6 && !done; c++) begin
            rd_start = 1'b0; WR = 1'b0;
            if (rd_busy) busy_c++;
            if (rd_reject) rej_c++;
            if (rd_valid) begin
                if (first_c < 0) first_c = c;
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_word"}, DW'(n), DW'(len));
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_data"},  rd_data, e);
                    check({tag, "_data6"}, DW'(rd_data2), DW'(e[DW2-1:0]));
                    check({tag, "_valid6"}, DW'(rd_valid2), DW'(1));
                    check({tag, "_addr"},  DW'(rd_address), DW'((base + n) % D));
                    check({tag, "_last"},  DW'(rd_last), DW'(n == len - 1));
                    last_e = e;
                end
                n++;
                if (rd_last) done = 1;
            end
            if (coll_idx >= 0 && c == coll_idx + 1) begin
                a = (base + coll_idx) % D;
                WR = 1'b1; wr_broadcast = 1'b0; wr_bank = BW'(coll_bank);
                wr_address_word = AW'(a); wr_data_word = coll_data;
                model[coll_bank][a] = coll_data;
            end
            if (c == mid_at) begin
                rd_start = 1'b1; rd_base = AW'(mid_base_v); rd_len = LW'(mid_len_v);
            end
            if (abort_at > 0 && n == abort_at && !aborted) begin
                RESET_N = 1'b0;
                #1;
                check({tag, "_rst_data"}, rd_data, '0);
                check({tag, "_rst_addr"}, DW'(rd_address), '0);
                check({tag, "_rst_state"}, DW'(dbg_state), '0);
                check_idle_outputs({tag, "_rst"});
                aborted = 1; done = 1;
            end
            @(negedge clk);
        end
        WR = 1'b0; rd_start = 1'b0;
        if (!aborted) begin
            check({tag, "_count"}, DW'(n), DW'(len));
            check({tag, "_first_lat"}, DW'(first_c), DW'(2));
            check({tag, "_busy_cycles"}, DW'(busy_c), DW'(len + 1));
            check({tag, "_no_reject"}, DW'(rej_c), '0);
            check_idle_outputs({tag, "_end"});
            check({tag, "_busy6"}, DW'(rd_busy2), '0);
            check({tag, "_hold"}, rd_data, last_e);
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; WR = 1'b0; wr_broadcast = 1'b0; wr_bank = '0;
        wr_address_word = '0; wr_data_word = '0; rd_start = 1'b0; rd_base = '0; rd_len = '0;
        for (int k = 0; k < NB; k++) for (int a = 0; a < D; a++) model[k][a] = '0;
        repeat (2) @(negedge clk);
        check("reset_data", rd_data, '0);
        check("reset_addr", DW'(rd_address), '0);
        check("reset_data6", DW'(rd_data2), '0);
        check_idle_outputs("reset");
        RESET_N = 1'b1;
        @(negedge clk);

        // Broadcast fill, then full-depth burst
        for (int a = 0; a < D; a++) do_write(1'b1, 0, a, W'(a + 'h100));
        run_burst("full", 0, 64, -1, 0, '0, 0, 0);

        // Single bank write, single-word burst
        do_write(1'b1, 0, 10, '0);
        do_write(1'b0, 5, 10, 17'h1ABCD);
        run_burst("single", 10, 1, -1, 0, '0, 0, 0);

        // Wrap, with an illegal start request ignored mid-burst
        mid_base_v = 0; mid_len_v = 0;
        run_burst("wrap", 62, 4, -1, 0, '0, 0, 2);

        // Rejects and the largest legal wrapping burst
        try_reject("rej_len0", 0, 0);
        try_reject("rej_len65", 0, 65);
        run_burst("max_wrap", 63, 64, -1, 0, '0, 0, 0);

        // Banks 6 and 7 exist only in the 8-bank instance
        do_write(1'b0, 7, 10, 17'h15555);
        do_write(1'b0, 6, 10, 17'h0AAAA);
        run_burst("bank7", 10, 1, -1, 0, '0, 0, 0);

        // Same-edge read/write collision on bank 2, then re-read
        do_write(1'b0, 2, 20, 17'h00011);
        run_burst("coll", 16, 8, 4, 2, 17'h00022, 0, 0);
        run_burst("reread", 20, 1, -1, 0, '0, 0, 0);

        // Reset mid-burst, then a normal burst with a legal start ignored mid-burst
        run_burst("abort", 0, 20, -1, 0, '0, 7, 0);
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("post_rst");
        end
        mid_base_v = 30; mid_len_v = 5;
        run_burst("post", 0, 3, -1, 0, '0, 0, 2);
        repeat (3) @(negedge clk);
        check_idle_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
